// File: rtl/pwm.sv
// ============================================================================
// Module   : pwm
// Function : Free-running PWM generator, period 2**CNT_WIDTH clocks, duty
//            latched at period boundaries. Define PWM_PERIOD_PULSE_EN to add
//            the period_start output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm #(
  parameter int CNT_WIDTH = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty_cycle,
  output logic       pwm_out
`ifdef PWM_PERIOD_PULSE_EN
  ,
  output logic       period_start
`endif
);

  localparam int                   CMP_W   = (CNT_WIDTH > 8) ? CNT_WIDTH : 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] counter;
  logic [7:0]           duty_active;
  logic [CMP_W-1:0]     cnt_ext;
  logic [CMP_W-1:0]     duty_ext;
  logic                 pwm_next;

  // Zero-extended unsigned compare; duties at or above the period saturate high.
  assign cnt_ext  = CMP_W'(counter);
  assign duty_ext = CMP_W'(duty_active);
  assign pwm_next = (cnt_ext < duty_ext);

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter     <= '0;
      pwm_out     <= 1'b0;
      duty_active <= duty_cycle;
    end else begin
      counter <= counter + 1'b1;
      pwm_out <= pwm_next;
      if (counter == CNT_MAX) begin
        duty_active <= duty_cycle;
      end
    end
  end

`ifdef PWM_PERIOD_PULSE_EN
  // Marks the cycle in which pwm_out shows the first sample of a period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_start <= 1'b0;
    end else begin
      period_start <= (counter == '0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm.sv
// ============================================================================
// Module   : tb_pwm
// Function : Self-checking bench for pwm: period-level reference model plus
//            directed literal checks and randomized duty/reset stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm;

  localparam int CW = 7;
  localparam int P  = 2 ** CW;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] duty_cycle = 8'd0;
  logic       pwm_out;
`ifdef PWM_PERIOD_PULSE_EN
  logic       period_start;
`endif

  int checks = 0;
  int fails  = 0;

  pwm #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .duty_cycle (duty_cycle),
    .pwm_out    (pwm_out)
`ifdef PWM_PERIOD_PULSE_EN
    ,
    .period_start (period_start)
`endif
  );

  always #5 clk = ~clk;

  // Reference: position within the period since release, and the duty that
  // governs the current period (captured at reset or at the previous period end).
  int unsigned pos = 0;
  int unsigned period_duty = 0;
  bit          exp_pwm = 1'b0;
  bit          exp_ps  = 1'b0;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      pos         = 0;
      period_duty = duty_cycle;
      exp_pwm     = 1'b0;
      exp_ps      = 1'b0;
    end else begin
      exp_pwm = (pos < ((period_duty < P) ? period_duty : P));
      exp_ps  = (pos == 0);
      if (pos == P - 1) period_duty = duty_cycle;
      pos = (pos + 1) % P;
    end
    model_valid = 1'b1;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check_bit("model pwm_out", pwm_out, exp_pwm);
`ifdef PWM_PERIOD_PULSE_EN
      check_bit("model period_start", period_start, exp_ps);
`endif
    end
  end

  task automatic do_reset(input logic [7:0] d, input int n);
    @(negedge clk);
    reset      = 1'b0;
    duty_cycle = d;
    repeat (n) @(negedge clk);
    check_bit("pwm_out in reset", pwm_out, 1'b0);
    reset = 1'b1;
  endtask

  task automatic run_count(input int n, output int highs, output int starts);
    highs  = 0;
    starts = 0;
    repeat (n) begin
      @(negedge clk);
      highs += int'(pwm_out);
`ifdef PWM_PERIOD_PULSE_EN
      starts += int'(period_start);
`endif
    end
  endtask

  initial begin
    int h;
    int s;
    int tot;
    logic [7:0] d;
    logic [7:0] edge_duties [5];

    // 50% duty, first-period shape and long run
    do_reset(8'd64, 2);
    run_count(64, h, s);
    check_int("duty64 first half highs", h, 64);
`ifdef PWM_PERIOD_PULSE_EN
    check_int("duty64 period_start in first half", s, 1);
`endif
    run_count(64, h, s);
    check_int("duty64 second half highs", h, 0);
    tot = 0;
    repeat (4) begin
      run_count(P, h, s);
      tot += h;
`ifdef PWM_PERIOD_PULSE_EN
      check_int("period_start per period", s, 1);
`endif
    end
    check_int("duty64 four periods highs", tot, 256);

    // Boundary duties
    edge_duties = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};
    for (int i = 0; i < 5; i++) begin
      do_reset(edge_duties[i], 1);
      run_count(P, h, s);
      check_int($sformatf("duty%0d highs", edge_duties[i]), h,
                (edge_duties[i] > P) ? P : int'(edge_duties[i]));
    end

    // Mid-period duty change at counter 10
    do_reset(8'd64, 2);
    run_count(10, h, s);
    duty_cycle = 8'd32;
    tot = h;
    run_count(P - 10, h, s);
    check_int("duty change current period highs", tot + h, 64);
    run_count(P, h, s);
    check_int("duty change next period highs", h, 32);

    // Reset at counter 50 while output is high
    do_reset(8'd64, 2);
    run_count(50, h, s);
    check_bit("pwm_out before mid reset", pwm_out, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_bit("pwm_out after mid reset", pwm_out, 1'b0);
    reset = 1'b1;
    run_count(64, h, s);
    check_int("restart first half highs", h, 64);
    run_count(64, h, s);
    check_int("restart second half highs", h, 0);

    // Randomized duty changes and resets, checked by the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       d = 8'd0;
        1:       d = 8'($urandom_range(120, 255));
        default: d = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 4) == 0) begin
        do_reset(d, $urandom_range(1, 3));
      end else begin
        duty_cycle = d;
      end
      repeat ($urandom_range(1, 200)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
